// File: rtl/cctrl_aurora_pkg.sv
// Shared types for the Aurora link sequencer: state encoding, status counter
// widths and the per-state reset output decode.
package cctrl_aurora_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ASSERT_PB  = 3'd1,
        ST_PMA        = 3'd2,
        ST_RELEASE_PB = 3'd3,
        ST_WAIT_UP    = 3'd4,
        ST_UP         = 3'd5,
        ST_BACKOFF    = 3'd6
    } seq_state_e;

    localparam int RETRY_W = 8;
    localparam int DROP_W  = 16;

    // Returns {reset_pb, pma_init} driven while in state s.
    function automatic logic [1:0] state_resets(seq_state_e s);
        case (s)
            ST_IDLE, ST_PMA:                          return 2'b11;
            ST_ASSERT_PB, ST_RELEASE_PB, ST_BACKOFF:  return 2'b10;
            default:                                  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/aurora_link_sequencer_if.sv
// Control/status bundle between the CSR/core side (master) and the sequencer (slave).
interface aurora_link_sequencer_if;

    logic                                 enable;
    logic                                 gt_pll_lock;
    logic                                 channel_up;
    logic                                 clear_counts;
    logic                                 reset_pb;
    logic                                 pma_init;
    logic                                 link_ok;
    logic [2:0]                           state;
    logic [cctrl_aurora_pkg::RETRY_W-1:0] retry_count;
    logic [cctrl_aurora_pkg::DROP_W-1:0]  drop_count;

    modport master (
        output enable, gt_pll_lock, channel_up, clear_counts,
        input  reset_pb, pma_init, link_ok, state, retry_count, drop_count
    );

    modport slave (
        input  enable, gt_pll_lock, channel_up, clear_counts,
        output reset_pb, pma_init, link_ok, state, retry_count, drop_count
    );

endinterface

// File: rtl/aurora_seq_timer.sv
// Loadable down-counter shared by all timed sequencer states; done while at zero.
module aurora_seq_timer #(
    parameter int TIMER_W = 24
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - TIMER_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/aurora_link_sequencer.sv
// Aurora 64b66b reset/bring-up sequencer with link-up qualify, timeout retry and
// drop restart. Define AURORA_SEQ_STATS_EN to implement drop_count.
module aurora_link_sequencer
    import cctrl_aurora_pkg::*;
#(
    parameter int PB_CYCLES       = 128,
    parameter int PMA_INIT_CYCLES = 1_000_000,
    parameter int LINKUP_TIMEOUT  = 10_000_000,
    parameter int BACKOFF_CYCLES  = 1_000_000,
    parameter int UP_QUALIFY      = 16,
    parameter int TIMER_W         = 24
) (
    input logic                    sysClk,
    input logic                    sysReset_n,
    aurora_link_sequencer_if.slave lnk
);

    localparam int QW = $clog2(UP_QUALIFY + 1);
    localparam logic [QW-1:0]      QUAL_LAST = QW'(UP_QUALIFY - 1);
    // Timer holds N-1 on entry so each state occupies exactly N cycles.
    localparam logic [TIMER_W-1:0] PB_LD  = TIMER_W'(PB_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PMA_LD = TIMER_W'(PMA_INIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_LD  = TIMER_W'(LINKUP_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BO_LD  = TIMER_W'(BACKOFF_CYCLES - 1);

    seq_state_e         state_q, state_d;
    logic [QW-1:0]      qual_q, qual_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               retry_inc;
    logic               tmr_load, tmr_done;
    logic [TIMER_W-1:0] tmr_val;
    logic               reset_pb_q, pma_init_q, link_ok_q;
    logic [1:0]         rst_pair;

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        case (state_q)
            ST_IDLE:       if (lnk.enable && lnk.gt_pll_lock) state_d = ST_ASSERT_PB;
            ST_ASSERT_PB:  if (tmr_done) state_d = ST_PMA;
            ST_PMA:        if (tmr_done) state_d = ST_RELEASE_PB;
            ST_RELEASE_PB: if (tmr_done) state_d = ST_WAIT_UP;
            ST_WAIT_UP: begin
                // Qualification completing on the timeout cycle still wins.
                if (lnk.channel_up && qual_q == QUAL_LAST) begin
                    state_d = ST_UP;
                end else if (tmr_done) begin
                    state_d   = ST_BACKOFF;
                    retry_inc = 1'b1;
                end
            end
            ST_UP:         if (!lnk.channel_up) state_d = ST_ASSERT_PB;
            ST_BACKOFF:    if (tmr_done) state_d = ST_ASSERT_PB;
            default:       state_d = ST_IDLE;
        endcase
        if (!lnk.gt_pll_lock && state_q != ST_IDLE && state_q != ST_ASSERT_PB) begin
            state_d   = ST_ASSERT_PB;
            retry_inc = 1'b0;
        end
        if (!lnk.enable) begin
            state_d   = ST_IDLE;
            retry_inc = 1'b0;
        end
    end

    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            ST_ASSERT_PB, ST_RELEASE_PB: tmr_val = PB_LD;
            ST_PMA:                      tmr_val = PMA_LD;
            ST_WAIT_UP:                  tmr_val = TO_LD;
            ST_BACKOFF:                  tmr_val = BO_LD;
            default:                     tmr_val = '0;
        endcase
    end

    assign qual_d   = (state_q == ST_WAIT_UP && lnk.channel_up) ? qual_q + QW'(1) : '0;
    assign retry_d  = lnk.clear_counts                  ? '0 :
                      (retry_inc && retry_q != '1)      ? retry_q + RETRY_W'(1) : retry_q;
    assign rst_pair = state_resets(state_d);

    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            state_q    <= ST_IDLE;
            qual_q     <= '0;
            retry_q    <= '0;
            reset_pb_q <= 1'b1;
            pma_init_q <= 1'b1;
            link_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            qual_q     <= qual_d;
            retry_q    <= retry_d;
            reset_pb_q <= rst_pair[1];
            pma_init_q <= rst_pair[0];
            link_ok_q  <= (state_d == ST_UP);
        end
    end

    aurora_seq_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk_i      (sysClk),
        .rst_ni     (sysReset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

`ifdef AURORA_SEQ_STATS_EN
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              drop_inc;

    // Only a genuine channel_up loss counts; enable/lock overrides do not.
    assign drop_inc = (state_q == ST_UP) && lnk.enable && lnk.gt_pll_lock && !lnk.channel_up;
    assign drop_d   = lnk.clear_counts             ? '0 :
                      (drop_inc && drop_q != '1)   ? drop_q + DROP_W'(1) : drop_q;

    always_ff @(posedge sysClk) begin
        if (!sysReset_n) drop_q <= '0;
        else             drop_q <= drop_d;
    end

    assign lnk.drop_count = drop_q;
`else
    assign lnk.drop_count = '0;
`endif

    assign lnk.reset_pb    = reset_pb_q;
    assign lnk.pma_init    = pma_init_q;
    assign lnk.link_ok     = link_ok_q;
    assign lnk.state       = state_q;
    assign lnk.retry_count = retry_q;

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Bench for aurora_link_sequencer: vector table, directed corner sequences and a
// randomized run checked every cycle against a duration-based reference model.
module tb_aurora_link_sequencer;

    localparam int PB  = 4;
    localparam int PMA = 20;
    localparam int TO  = 50;
    localparam int BO  = 10;
    localparam int UQ  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aurora_link_sequencer_if lnk();

    aurora_link_sequencer #(
        .PB_CYCLES       (PB),
        .PMA_INIT_CYCLES (PMA),
        .LINKUP_TIMEOUT  (TO),
        .BACKOFF_CYCLES  (BO),
        .UP_QUALIFY      (UQ),
        .TIMER_W         (24)
    ) dut (
        .sysClk     (clk),
        .sysReset_n (rst_n),
        .lnk        (lnk)
    );

    int ncomp = 0;
    int nfail = 0;
    int sb_shown = 0;
    bit sb_on = 1'b0;

    typedef struct {
        bit en; bit lock; bit cu; int n;
        int st; bit rpb; bit pma; bit lok;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        ncomp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sts();
        return int'(lnk.state);
    endfunction

    task automatic wait_state(input int s, input string nm);
        int b;
        b = 0;
        while (sts() != s && b < 300) begin
            step(1);
            b++;
        end
        chk(nm, sts(), s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lnk.enable = 1'b0; lnk.gt_pll_lock = 1'b1;
        lnk.channel_up = 1'b0; lnk.clear_counts = 1'b0;
        step(2);
        rst_n = 1'b1;
        sb_on = 1'b1;
    endtask

    // ---------------- reference model: phase + cycles remaining ----------------
    int m_st, m_left, m_run, m_retry, m_drop;

    function automatic int dur(input int s);
        case (s)
            1, 3:    return PB;
            2:       return PMA;
            4:       return TO;
            6:       return BO;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int nxt;
        bit rev, dev;
        if (!rst_n) begin
            m_st = 0; m_left = 0; m_run = 0; m_retry = 0; m_drop = 0;
        end else begin
            nxt = m_st; rev = 1'b0; dev = 1'b0;
            case (m_st)
                0: if (lnk.enable && lnk.gt_pll_lock) nxt = 1;
                1: if (m_left == 1) nxt = 2;
                2: if (m_left == 1) nxt = 3;
                3: if (m_left == 1) nxt = 4;
                4: if (lnk.channel_up && m_run + 1 >= UQ) nxt = 5;
                   else if (m_left == 1) begin nxt = 6; rev = 1'b1; end
                5: if (!lnk.channel_up) begin nxt = 1; dev = 1'b1; end
                6: if (m_left == 1) nxt = 1;
                default: nxt = 0;
            endcase
            if (!lnk.gt_pll_lock && m_st != 0 && m_st != 1) begin nxt = 1; rev = 0; dev = 0; end
            if (!lnk.enable) begin nxt = 0; rev = 0; dev = 0; end
            if (lnk.clear_counts) begin
                m_retry = 0; m_drop = 0;
            end else begin
                if (rev && m_retry < 255)   m_retry++;
                if (dev && m_drop  < 65535) m_drop++;
            end
            m_run  = (m_st == 4 && lnk.channel_up) ? m_run + 1 : 0;
            m_left = (nxt != m_st) ? dur(nxt) : m_left - 1;
            m_st   = nxt;
        end
    end

    function automatic int exp_drop();
`ifdef AURORA_SEQ_STATS_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        bit e_rpb, e_pma, e_lok;
        if (sb_on) begin
            e_rpb = (m_st == 0 || m_st == 1 || m_st == 2 || m_st == 3 || m_st == 6);
            e_pma = (m_st == 0 || m_st == 2);
            e_lok = (m_st == 5);
            ncomp++;
            if (sts() != m_st || lnk.reset_pb != e_rpb || lnk.pma_init != e_pma ||
                lnk.link_ok != e_lok || int'(lnk.retry_count) != m_retry ||
                int'(lnk.drop_count) != exp_drop()) begin
                nfail++;
                if (sb_shown < 10) begin
                    sb_shown++;
                    $display("FAIL model t=%0t: got st=%0d rpb=%0b pma=%0b ok=%0b rc=%0d dc=%0d, expected st=%0d rpb=%0b pma=%0b ok=%0b rc=%0d dc=%0d",
                             $time, sts(), lnk.reset_pb, lnk.pma_init, lnk.link_ok,
                             lnk.retry_count, lnk.drop_count,
                             m_st, e_rpb, e_pma, e_lok, m_retry, exp_drop());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_lo, pma_hi, pma_first, cnt;
        bit pat[6];

        // ---------------- reset values ----------------
        do_reset();
        chk("rst_state", sts(), 0);
        chk("rst_reset_pb", int'(lnk.reset_pb), 1);
        chk("rst_pma_init", int'(lnk.pma_init), 1);
        chk("rst_link_ok", int'(lnk.link_ok), 0);
        chk("rst_retry", int'(lnk.retry_count), 0);
        chk("rst_drop", int'(lnk.drop_count), 0);

        // ---------------- vector table ----------------
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1,  0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3,  0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1,  1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 3,  1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1,  2, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 19, 2, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1,  3, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 4,  4, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2,  4, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1,  5, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1,  1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1,  0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            lnk.enable = tbl[i].en; lnk.gt_pll_lock = tbl[i].lock; lnk.channel_up = tbl[i].cu;
            step(tbl[i].n);
            chk($sformatf("vec%0d_state", i), sts(), tbl[i].st);
            chk($sformatf("vec%0d_reset_pb", i), int'(lnk.reset_pb), int'(tbl[i].rpb));
            chk($sformatf("vec%0d_pma_init", i), int'(lnk.pma_init), int'(tbl[i].pma));
            chk($sformatf("vec%0d_link_ok", i), int'(lnk.link_ok), int'(tbl[i].lok));
        end

        // ---------------- nominal bring-up ----------------
        do_reset();
        lnk.enable = 1'b1;
        first_lo = -1; pma_hi = 0; pma_first = -1;
        for (int i = 1; i <= 60 && first_lo < 0; i++) begin
            step(1);
            if (!lnk.reset_pb) first_lo = i;
            else if (lnk.pma_init) begin
                pma_hi++;
                if (pma_first < 0) pma_first = i;
            end
        end
        chk("nom_reset_pb_len", first_lo - 1, 28);
        chk("nom_pma_len", pma_hi, 20);
        chk("nom_pma_start", pma_first, 5);
        chk("nom_wait_up", sts(), 4);
        step(5);
        lnk.channel_up = 1'b1;
        step(2);
        chk("nom_link_ok_e7", int'(lnk.link_ok), 0);
        step(1);
        chk("nom_link_ok_e8", int'(lnk.link_ok), 1);
        chk("nom_state_up", sts(), 5);

        // ---------------- link drop ----------------
        lnk.channel_up = 1'b0;
        step(1);
        chk("drop_link_ok", int'(lnk.link_ok), 0);
        chk("drop_state", sts(), 1);
`ifdef AURORA_SEQ_STATS_EN
        chk("drop_count", int'(lnk.drop_count), 1);
`else
        chk("drop_count", int'(lnk.drop_count), 0);
`endif

        // ---------------- lock loss during PMA ----------------
        wait_state(2, "lock_enter_pma");
        step(3);
        lnk.gt_pll_lock = 1'b0;
        step(1);
        chk("lock_state", sts(), 1);
        chk("lock_retry", int'(lnk.retry_count), 0);
        chk("lock_drop", int'(lnk.drop_count), exp_drop());
        lnk.gt_pll_lock = 1'b1;

        // ---------------- enable low mid-WAIT_UP ----------------
        wait_state(4, "en_enter_wait");
        step(10);
        lnk.enable = 1'b0;
        step(1);
        chk("en_state", sts(), 0);
        chk("en_reset_pb", int'(lnk.reset_pb), 1);
        chk("en_pma_init", int'(lnk.pma_init), 1);

        // ---------------- synchronous reset mid-PMA ----------------
        lnk.enable = 1'b1;
        wait_state(2, "srst_enter_pma");
        step(5);
        rst_n = 1'b0;
        step(1);
        chk("srst_state", sts(), 0);
        chk("srst_reset_pb", int'(lnk.reset_pb), 1);
        chk("srst_pma_init", int'(lnk.pma_init), 1);
        chk("srst_link_ok", int'(lnk.link_ok), 0);
        chk("srst_retry", int'(lnk.retry_count), 0);
        chk("srst_drop", int'(lnk.drop_count), 0);
        rst_n = 1'b1;
        step(1);
        chk("srst_restart", sts(), 1);

        // ---------------- qualify glitch ----------------
        do_reset();
        lnk.enable = 1'b1;
        wait_state(4, "gl_enter_wait");
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int j = 0; j < 6; j++) begin
            lnk.channel_up = pat[j];
            step(1);
            chk($sformatf("gl_link_ok_%0d", j), int'(lnk.link_ok), (j == 5) ? 1 : 0);
        end

        // ---------------- timeout retry ----------------
        do_reset();
        lnk.enable = 1'b1;
        wait_state(4, "to_enter_wait");
        cnt = 0;
        while (sts() == 4 && cnt < 200) begin cnt++; step(1); end
        chk("to_wait_len", cnt, 50);
        chk("to_backoff", sts(), 6);
        chk("to_retry1", int'(lnk.retry_count), 1);
        cnt = 0;
        while (sts() == 6 && cnt < 200) begin cnt++; step(1); end
        chk("to_backoff_len", cnt, 10);
        chk("to_restart", sts(), 1);
        // clear landing on the timeout edge beats the increment
        wait_state(4, "to_enter_wait2");
        step(49);
        lnk.clear_counts = 1'b1;
        step(1);
        lnk.clear_counts = 1'b0;
        chk("to_clr_state", sts(), 6);
        chk("to_clr_prio", int'(lnk.retry_count), 0);
        step(310 * (2 * PB + PMA + TO + BO));
        chk("to_retry_sat", int'(lnk.retry_count), 255);
        lnk.clear_counts = 1'b1;
        step(1);
        lnk.clear_counts = 1'b0;
        chk("to_retry_clr", int'(lnk.retry_count), 0);

        // ---------------- randomized run vs model ----------------
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            lnk.enable      = ($urandom_range(0, 299) != 0);
            lnk.gt_pll_lock = ($urandom_range(0, 149) != 0);
            if ((i / 500) % 2 == 1)
                lnk.channel_up = ($urandom_range(0, 19) == 0);
            else if ($urandom_range(0, 7) == 0)
                lnk.channel_up = ~lnk.channel_up;
            lnk.clear_counts = ($urandom_range(0, 199) == 0);
            step(1);
        end
        lnk.clear_counts = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
